uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter CLK_PER_BIT, default 868; clock cycles per UART bit (100 MHz / 115200); legal range 4..65535.
REQ-002 The block SHALL have parameter FIFO_WIDTH, default 2; log2 of the FIFO depth (default depth 4).
REQ-003 The block SHALL have port CLK, input, 1 bit; the single system clock, with all logic on its rising edge.
REQ-004 The block SHALL have port RSTN, input, 1 bit; asynchronous active-low reset.
REQ-005 The block SHALL have port UART_RX, input, 1 bit; asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 The block SHALL have port rx_data, output, 8 bits; byte at the FIFO head.
REQ-007 The block SHALL have port rx_valid, output, 1 bit; FIFO not empty, so rx_data is valid.
REQ-008 The block SHALL have port rx_ready, input, 1 bit; consumer accepts the head byte.
REQ-009 The block SHALL have port frame_err, output, 1 bit; one-cycle pulse when a stop bit is sampled low.
REQ-010 The block SHALL have port overrun, output, 1 bit; one-cycle pulse when a received byte is dropped because the FIFO is full.

Function
REQ-011 UART_RX SHALL pass through a 2-flop synchronizer (both flops reset to 1); all receive logic uses the synchronized value rx_s.
REQ-012 The receiver FSM SHALL have states IDLE, START, DATA, STOP, with a bit-timing counter (16 bits) and a bit index (3 bits).
REQ-013 IDLE: when rx_s==0, the FSM SHALL go to START and load the counter for a half-bit wait of CLK_PER_BIT/2 cycles (integer division).
REQ-014 START: at half-bit expiry, if rx_s==0 the FSM SHALL go to DATA with bit index 0; if rx_s==1 it SHALL treat the event as a glitch, return to IDLE, and push nothing.
REQ-015 DATA: the FSM SHALL sample rx_s every CLK_PER_BIT cycles into shift register bit [index] (LSB first); after bit 7 it SHALL go to STOP.
REQ-016 STOP: after CLK_PER_BIT cycles the FSM SHALL sample rx_s. If 1, it pushes the byte to the FIFO. If 0, it pulses frame_err and discards the byte. Either way it returns to IDLE.
REQ-017 After a framing error, IDLE SHALL NOT start a new frame until rx_s has been seen high for at least 1 cycle, so a break condition yields a single frame_err.
REQ-018 The FIFO SHALL be 2**FIFO_WIDTH entries with first-word fall-through: rx_data = mem[rd_ptr], rx_valid = (count != 0).
REQ-019 rd_ptr and wr_ptr SHALL be FIFO_WIDTH bits and wrap modulo depth; count SHALL be FIFO_WIDTH+1 bits.
REQ-020 Pop SHALL occur when rx_valid && rx_ready; rx_ready while empty SHALL have no effect.
REQ-021 Push while full with a simultaneous pop SHALL be accepted, with count unchanged and no overrun.
REQ-022 Push while full without a pop SHALL drop the byte, pulse overrun for 1 cycle, and leave FIFO contents unchanged.
REQ-023 Simultaneous push and pop while not full SHALL leave count unchanged.
REQ-024 Latency: rx_valid SHALL rise on the cycle after the stop-bit sample cycle when the FIFO was empty.
REQ-025 rx_data SHALL remain stable while rx_valid=1 and rx_ready=0.

Reset
REQ-026 While RSTN=0, the block SHALL asynchronously force: FSM=IDLE, synchronizer flops=1, counters/pointers/count=0, rx_valid=0, frame_err=0, overrun=0, rx_data=8'h00 (memory contents need not be reset).
REQ-027 Reset asserted mid-frame SHALL abort the frame with no push and no pulse; after RSTN rises, reception SHALL resume at the next falling edge on the line.
REQ-028 Reset deassertion SHALL be consumed synchronously to CLK; the first FSM transition is allowed on the second CLK edge after RSTN rises.

Verification (CLK_PER_BIT=16, FIFO_WIDTH=2)
REQ-029 Send 8'hA5 with rx_ready=0: rx_valid SHALL rise and rx_data SHALL equal 8'hA5 with no pulses; raising rx_ready for 1 cycle SHALL clear rx_valid.
REQ-030 Drive a 5-cycle low glitch on an idle line: there SHALL be no push, no frame_err, and the FSM SHALL return to IDLE.
REQ-031 Send 8'h3C with the stop bit held low: frame_err SHALL pulse exactly once, with rx_valid remaining 0; a following 8'h55 SHALL be received correctly.
REQ-032 Send 5 bytes 8'h01..8'h05 with rx_ready=0: the 5th SHALL pulse overrun; the pops SHALL return 01, 02, 03, 04 in order.
REQ-033 Fill the FIFO with 4 bytes, then hold rx_ready=1 during the 5th stop sample: there SHALL be no overrun, and 8'h05 SHALL be delivered last.
REQ-034 Assert RSTN=0 at data bit 3 of 8'hFF: there SHALL be no push, and all outputs SHALL read reset values; a subsequent 8'h81 SHALL be received intact.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, LSB first) feeding a small first-word-fall-through FIFO.
// The line is double-synchronized, sampled mid-bit, and completed bytes are
// queued for a ready/valid consumer. Framing errors and FIFO overruns are
// reported as single-cycle pulses.
module uart_rx_fifo #(
    parameter int CLK_PER_BIT = 868,
    parameter int FIFO_WIDTH  = 2
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       UART_RX,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int                  DEPTH    = 1 << FIFO_WIDTH;
    localparam logic [15:0]         BIT_M1   = 16'(CLK_PER_BIT - 1);
    localparam logic [15:0]         HALF_M1  = 16'(CLK_PER_BIT / 2 - 1);
    localparam logic [FIFO_WIDTH:0] FULL_CNT = (FIFO_WIDTH + 1)'(DEPTH);
    localparam logic [FIFO_WIDTH:0] CNT_ONE  = (FIFO_WIDTH + 1)'(1);
    localparam logic [FIFO_WIDTH-1:0] PTR_ONE = FIFO_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Synchronizer and receiver state
    logic        sync1_q, rx_s_q;
    logic        en_q;
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        brk_q, brk_d;
    logic        frame_err_q, frame_err_d;
    logic        push;

    // FIFO state
    logic [7:0]            mem_q [DEPTH];
    logic [FIFO_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_WIDTH:0]   count_q, count_d;
    logic                  overrun_q, overrun_d;
    logic                  pop, full, wr_en;

    // Two-flop synchronizer on the asynchronous line; idles high out of reset.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= UART_RX;
            rx_s_q  <= sync1_q;
        end
    end

    // Receiver next-state: mid-bit sampling, glitch rejection, break lockout.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        brk_d       = brk_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        if (en_q) begin
            unique case (state_q)
                IDLE: begin
                    // After a framing error the line must return high before
                    // a new start bit is accepted, so a break reports once.
                    if (brk_q) begin
                        if (rx_s_q) brk_d = 1'b0;
                    end else if (!rx_s_q) begin
                        state_d = START;
                        cnt_d   = HALF_M1;
                    end
                end
                START: begin
                    if (cnt_q == 16'd0) begin
                        if (!rx_s_q) begin
                            state_d = DATA;
                            cnt_d   = BIT_M1;
                            idx_d   = 3'd0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                DATA: begin
                    if (cnt_q == 16'd0) begin
                        shift_d[idx_q] = rx_s_q;
                        cnt_d          = BIT_M1;
                        if (idx_q == 3'd7) state_d = STOP;
                        else               idx_d   = idx_q + 3'd1;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                STOP: begin
                    if (cnt_q == 16'd0) begin
                        state_d = IDLE;
                        if (rx_s_q) begin
                            push = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                            brk_d       = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FIFO bookkeeping: a push into a full FIFO is accepted only alongside a pop.
    always_comb begin
        pop       = rx_valid && rx_ready;
        full      = (count_q == FULL_CNT);
        wr_en     = push && (!full || pop);
        overrun_d = push && full && !pop;
        rd_ptr_d  = pop   ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        wr_ptr_d  = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control registers; en_q delays the first FSM step until the second edge after reset release.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            en_q        <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            idx_q       <= 3'd0;
            brk_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            en_q        <= 1'b1;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            brk_q       <= brk_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    // Data-path registers carry no reset: shift register and FIFO storage.
    always_ff @(posedge CLK) begin
        shift_q <= shift_d;
        if (wr_en) mem_q[wr_ptr_q] <= shift_q;
    end

    // Head of FIFO is presented directly; forced to zero while empty.
    always_comb begin
        rx_valid  = (count_q != '0);
        rx_data   = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
        frame_err = frame_err_q;
        overrun   = overrun_q;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a frame-level reference model predicts
// FIFO contents and pulses from transmitted frames; a compare process checks
// every cycle, and directed scenarios add literal expectations.
module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int FW    = 2;
    localparam int DEPTH = 4;
    localparam int HALF  = CPB / 2;

    logic       CLK = 1'b0;
    logic       RSTN = 1'b0;
    logic       UART_RX = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    uart_rx_fifo #(.CLK_PER_BIT(CPB), .FIFO_WIDTH(FW)) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .UART_RX   (UART_RX),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         t;
        logic [7:0] b;
        bit         ok;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] q[$];
    bit         fe_exp = 1'b0;
    bit         ov_exp = 1'b0;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    bit         rand_rdy = 1'b0;
    int         rdy_at = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: at the scheduled stop-sample cycle of each frame, either
    // push the byte (dropping it with an overrun if full and not popped) or
    // flag a framing error. Pops happen whenever the queue is non-empty and ready.
    always @(posedge CLK) begin : model
        bit  pop_m;
        bit  push_m;
        ev_t e;
        cyc <= cyc + 1;
        fe_exp = 1'b0;
        ov_exp = 1'b0;
        if (!RSTN) begin
            q.delete();
            evq.delete();
        end else begin
            pop_m  = (q.size() != 0) && rx_ready;
            push_m = 1'b0;
            if (evq.size() != 0 && evq[0].t == cyc) begin
                e = evq.pop_front();
                if (e.ok) push_m = 1'b1;
                else      fe_exp = 1'b1;
            end
            if (pop_m) void'(q.pop_front());
            if (push_m) begin
                if (q.size() < DEPTH) q.push_back(e.b);
                else                  ov_exp = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (!RSTN) begin
            check("rst_valid", {31'd0, rx_valid}, 32'd0);
            check("rst_data", {24'd0, rx_data}, 32'd0);
            check("rst_frame_err", {31'd0, frame_err}, 32'd0);
            check("rst_overrun", {31'd0, overrun}, 32'd0);
        end else begin
            check("valid", {31'd0, rx_valid}, {31'd0, q.size() != 0});
            if (q.size() != 0) check("data", {24'd0, rx_data}, {24'd0, q[0]});
            check("frame_err", {31'd0, frame_err}, {31'd0, fe_exp});
            check("overrun", {31'd0, overrun}, {31'd0, ov_exp});
        end
        if (frame_err) fe_cnt++;
        if (overrun)   ov_cnt++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        if (rand_rdy) rx_ready = ($urandom_range(0, 2) == 0);
        else          rx_ready = (cyc == rdy_at);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic hold(input logic v);
        UART_RX = v;
        repeat (CPB) tick();
    endtask

    // Transmit one frame starting now; the line falls in the current cycle,
    // so the stop bit is sampled 2 (sync) + CPB/2 + 9*CPB cycles later.
    task automatic send(input logic [7:0] b, input bit ok, input int extra_low, input bit pop_at_stop);
        ev_t e;
        e.t = cyc + 2 + HALF + 9 * CPB;
        e.b = b;
        e.ok = ok;
        evq.push_back(e);
        if (pop_at_stop) rdy_at = e.t;
        hold(1'b0);
        for (int i = 0; i < 8; i++) hold(b[i]);
        hold(ok);
        if (!ok) repeat (extra_low) tick();
        UART_RX = 1'b1;
        rdy_at = -1;
    endtask

    task automatic pop_expect(input string nm, input logic [7:0] exp);
        int n;
        n = 0;
        while (!rx_valid && n < 3000) begin
            tick();
            n++;
        end
        check({nm, "_avail"}, {31'd0, rx_valid}, 32'd1);
        check(nm, {24'd0, rx_data}, {24'd0, exp});
        rx_ready = 1'b1;
        tick();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int f0;
        int o0;
        logic [7:0] rb;
        bit rok;

        RSTN = 1'b0;
        UART_RX = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RSTN = 1'b1;
        idle(10);

        // Single byte held, then popped.
        send(8'hA5, 1'b1, 0, 1'b0);
        idle(20);
        check("a5_valid", {31'd0, rx_valid}, 32'd1);
        check("a5_data", {24'd0, rx_data}, 32'h0000_00A5);
        check("a5_no_fe", fe_cnt, 0);
        check("a5_no_ov", ov_cnt, 0);
        pop_expect("a5_pop", 8'hA5);
        check("a5_cleared", {31'd0, rx_valid}, 32'd0);

        // Short low glitch on an idle line.
        f0 = fe_cnt;
        UART_RX = 1'b0;
        idle(5);
        UART_RX = 1'b1;
        idle(40);
        check("glitch_no_fe", fe_cnt - f0, 0);
        check("glitch_no_push", {31'd0, rx_valid}, 32'd0);

        // Bad stop bit followed by a held-low break, then a good byte.
        f0 = fe_cnt;
        send(8'h3C, 1'b0, 40, 1'b0);
        idle(20);
        check("break_fe_once", fe_cnt - f0, 1);
        check("break_no_push", {31'd0, rx_valid}, 32'd0);
        send(8'h55, 1'b1, 0, 1'b0);
        idle(5);
        pop_expect("after_break", 8'h55);

        // Overrun on the fifth byte with no consumer.
        o0 = ov_cnt;
        for (int i = 1; i <= 5; i++) begin
            send(8'(i), 1'b1, 0, 1'b0);
            idle(3);
        end
        idle(20);
        check("ovr_once", ov_cnt - o0, 1);
        for (int i = 1; i <= 4; i++) pop_expect("ovr_pop", 8'(i));
        check("ovr_drained", {31'd0, rx_valid}, 32'd0);

        // Full FIFO with a pop coincident with the fifth stop sample.
        for (int i = 1; i <= 4; i++) begin
            send(8'(i), 1'b1, 0, 1'b0);
            idle(3);
        end
        o0 = ov_cnt;
        send(8'h05, 1'b1, 0, 1'b1);
        idle(20);
        check("full_pop_no_ov", ov_cnt - o0, 0);
        for (int i = 2; i <= 5; i++) pop_expect("full_pop", 8'(i));
        check("full_pop_drained", {31'd0, rx_valid}, 32'd0);

        // Reset in the middle of data bit 3 of 8'hFF, with a byte queued.
        send(8'h42, 1'b1, 0, 1'b0);
        idle(5);
        check("pre_rst_valid", {31'd0, rx_valid}, 32'd1);
        hold(1'b0);
        hold(1'b1);
        hold(1'b1);
        hold(1'b1);
        UART_RX = 1'b1;
        repeat (HALF) tick();
        RSTN = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
        check("mid_rst_data", {24'd0, rx_data}, 32'd0);
        check("mid_rst_fe", {31'd0, frame_err}, 32'd0);
        check("mid_rst_ov", {31'd0, overrun}, 32'd0);
        idle(4);
        RSTN = 1'b1;
        idle(4 * CPB);
        check("post_rst_no_push", {31'd0, rx_valid}, 32'd0);
        send(8'h81, 1'b1, 0, 1'b0);
        idle(5);
        pop_expect("post_rst", 8'h81);

        // Randomized traffic with a randomly stalling consumer.
        rand_rdy = 1'b1;
        for (int n = 0; n < 40; n++) begin
            rb  = 8'($urandom);
            rok = ($urandom_range(0, 7) != 0);
            send(rb, rok, rok ? 0 : int'($urandom_range(0, 20)), 1'b0);
            idle(int'($urandom_range(2, 40)));
        end
        rand_rdy = 1'b0;
        for (int n = 0; n < 10; n++) begin
            rx_ready = 1'b1;
            @(posedge CLK);
            #1;
        end
        rx_ready = 1'b0;
        idle(5);
        check("final_empty", {31'd0, rx_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
